// File: rtl/ifetch.sv
// Single-entry instruction fetch stage: requests pc from instruction memory, holds the
// returned word for decode and handles redirects. Define IFETCH_TIMEOUT_EN to build the WAIT timeout and ERR state.
module ifetch #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NOP_INST       = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        stall,
   output logic        fetch_err
);

`ifdef IFETCH_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, ERR} state_t;
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`else
   typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] instPc_q, instPc_d;
   logic        drop_q, drop_d;
   logic        inErr;

`ifdef IFETCH_TIMEOUT_EN
   logic [CNT_W-1:0] tmoCnt_q, tmoCnt_d;
   logic             err_q, err_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         inst_q   <= NOP_INST;
         instPc_q <= '0;
         drop_q   <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         tmoCnt_q <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         inst_q   <= inst_d;
         instPc_q <= instPc_d;
         drop_q   <= drop_d;
`ifdef IFETCH_TIMEOUT_EN
         tmoCnt_q <= tmoCnt_d;
         err_q    <= err_d;
`endif
      end
   end

   // A flush seen while a word is in flight but without its ack marks that ack as stale.
   always_comb begin
      state_d  = state_q;
      inst_d   = inst_q;
      instPc_d = instPc_q;
      drop_d   = drop_q;
`ifdef IFETCH_TIMEOUT_EN
      tmoCnt_d = '0;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: state_d = REQ;
         REQ, WAIT: begin
            if (imem_ack) begin
               if (flush || drop_q) begin
                  state_d = REQ;
                  drop_d  = 1'b0;
               end else begin
                  state_d  = FULL;
                  inst_d   = imem_rdata;
                  instPc_d = pc;
               end
            end else begin
               state_d = WAIT;
               if (flush) begin
                  drop_d = 1'b1;
               end
`ifdef IFETCH_TIMEOUT_EN
               if (state_q == WAIT) begin
                  if (tmoCnt_q == CNT_LAST) begin
                     state_d = ERR;
                     err_d   = 1'b1;
                  end else begin
                     tmoCnt_d = tmoCnt_q + 1'b1;
                  end
               end
`endif
            end
         end
         FULL: begin
            if (flush || inst_ready) begin
               state_d = REQ;
            end
         end
`ifdef IFETCH_TIMEOUT_EN
         ERR: state_d = ERR;
`endif
         default: state_d = IDLE;
      endcase
   end

`ifdef IFETCH_TIMEOUT_EN
   assign inErr     = (state_q == ERR);
   assign fetch_err = ~rst & err_q;
`else
   assign inErr     = 1'b0;
   assign fetch_err = 1'b0;
`endif

   // Outputs are masked by rst so the reset values appear while rst is held, not one edge later.
   assign imem_req   = ~rst & ((state_q == REQ) | (state_q == WAIT));
   assign imem_addr  = pc;
   assign inst_valid = ~rst & (state_q == FULL);
   assign inst       = inst_valid ? inst_q : NOP_INST;
   assign inst_pc    = rst ? '0 : instPc_q;
   assign stall      = rst | inErr | ~((inst_valid & inst_ready) | flush);

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios followed by randomized traffic, all checked
// against a transaction-level model of the fetch stage.
module tb_ifetch;
   localparam logic [31:0] NOP = 32'h00000013;
   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst, flush, imem_ack, inst_ready;
   logic [31:0] pc, imem_rdata;
   logic        imem_req, inst_valid, stall, fetch_err;
   logic [31:0] imem_addr, inst, inst_pc;

   int testCount = 0;
   int failCount = 0;

   // Model: what the stage holds and owes, not how it encodes it.
   bit          mGap = 1'b1, mBusy = 1'b0, mInWait = 1'b0, mValid = 1'b0, mDrop = 1'b0, mErr = 1'b0;
   int          mWaitCnt = 0;
   logic [31:0] mInst = NOP, mInstPc = '0;
   bit          lastStall;

   ifetch #(.TIMEOUT_CYCLES(TMO), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .pc(pc), .flush(flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .stall(stall), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      bit eValid;
      eValid    = !rst && mValid;
      lastStall = (rst || mErr) ? 1'b1 : !((eValid && inst_ready) || flush);
      check("imem_req",   imem_req,   {31'b0, !rst && mBusy});
      check("imem_addr",  imem_addr,  pc);
      check("inst_valid", inst_valid, {31'b0, eValid});
      check("inst",       inst,       eValid ? mInst : NOP);
      check("inst_pc",    inst_pc,    rst ? 32'h0 : mInstPc);
      check("stall",      stall,      {31'b0, lastStall});
      check("fetch_err",  fetch_err,  {31'b0, !rst && mErr});
   endtask

   task automatic applyStimulus(input bit r, input bit f, input bit a, input logic [31:0] d, input bit rdy);
      rst = r; flush = f; imem_ack = a; imem_rdata = d; inst_ready = rdy;
      #1;
      checkOutput();
   endtask

   task automatic modelUpdate();
      if (rst) begin
         mGap = 1; mBusy = 0; mInWait = 0; mValid = 0; mDrop = 0; mErr = 0; mWaitCnt = 0; mInstPc = '0;
      end else if (mErr) begin
         mErr = 1;
      end else if (mGap) begin
         mGap = 0; mBusy = 1; mInWait = 0;
      end else if (mValid) begin
         if (flush || inst_ready) begin
            mValid = 0; mBusy = 1; mInWait = 0;
         end
      end else if (mBusy) begin
         if (imem_ack) begin
            mWaitCnt = 0; mInWait = 0;
            if (flush || mDrop) mDrop = 0;
            else begin
               mValid = 1; mBusy = 0; mInst = imem_rdata; mInstPc = pc;
            end
         end else begin
            if (flush) mDrop = 1;
            if (mInWait) begin
               mWaitCnt++;
`ifdef IFETCH_TIMEOUT_EN
               if (mWaitCnt == TMO) begin
                  mErr = 1; mBusy = 0;
               end
`endif
            end
            mInWait = 1;
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   initial begin
      int reqCycles;
      logic [31:0] rnd;
      bit r, f, s;

      pc = '0;
      repeat (2) begin
         applyStimulus(1, 0, 1, 32'h00500093, 0);
         advance();
      end

      // Release reset with ack tied high: IDLE gap, then REQ with immediate ack.
      repeat (2) begin
         applyStimulus(0, 0, 1, 32'h00500093, 0);
         advance();
      end
      check("first_valid", inst_valid, 32'h1);
      check("first_inst",  inst,       32'h00500093);
      check("first_pc",    inst_pc,    32'h0);

      // Decode stalls for five cycles; the held word must not move.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 1, 32'h11111111, 0);
         check("hold_stall", stall, 32'h1);
         advance();
         check("hold_valid", inst_valid, 32'h1);
         check("hold_inst",  inst,       32'h00500093);
         check("hold_req",   imem_req,   32'h0);
      end

      applyStimulus(0, 0, 0, 32'h0, 1);
      check("hs_stall", stall, 32'h0);
      advance();
      pc = 32'h10;

      // Ack arrives three cycles late.
      reqCycles = 0;
      for (int i = 0; i < 4; i++) begin
         if (imem_req) reqCycles++;
         applyStimulus(0, 0, (i == 3), 32'h00A00113, 0);
         advance();
      end
      check("late_req_cycles", reqCycles, 32'd4);
      check("late_pc",         inst_pc,   32'h10);
      check("late_inst",       inst,      32'h00A00113);

      // Flush while waiting: the stale ack is dropped and the new pc is requested.
      applyStimulus(0, 0, 0, 32'h0, 1);
      advance();
      pc = 32'h14;
      applyStimulus(0, 0, 0, 32'h0, 0);
      advance();
      applyStimulus(0, 1, 0, 32'h0, 0);
      advance();
      pc = 32'h40;
      applyStimulus(0, 0, 1, 32'hDEADBEEF, 0);
      advance();
      check("drop_valid", inst_valid, 32'h0);
      check("drop_req",   imem_req,   32'h1);
      check("drop_addr",  imem_addr,  32'h40);
      applyStimulus(0, 0, 1, 32'h00000033, 0);
      advance();
      check("refetch_pc",   inst_pc, 32'h40);
      check("refetch_inst", inst,    32'h00000033);

      // Flush and ready together in FULL.
      applyStimulus(0, 1, 0, 32'h0, 1);
      check("flush_hs_stall", stall, 32'h0);
      advance();
      pc = 32'h80;
      check("flush_hs_valid", inst_valid, 32'h0);
      check("flush_hs_req",   imem_req,   32'h1);

      // Memory never answers.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 0, 0, 32'h0, 0);
         advance();
      end
`ifdef IFETCH_TIMEOUT_EN
      check("tmo_err", fetch_err, 32'h1);
      check("tmo_req", imem_req,  32'h0);
      applyStimulus(0, 1, 1, 32'h0, 1);
      check("tmo_stall", stall, 32'h1);
      advance();
      check("tmo_sticky", fetch_err, 32'h1);
`else
      check("noack_err", fetch_err, 32'h0);
      check("noack_req", imem_req,  32'h1);
`endif

      applyStimulus(1, 0, 0, 32'h0, 0);
      advance();
      pc = '0;

      // Randomized traffic; the PC register is emulated from the model's stall.
      for (int n = 0; n < 1500; n++) begin
         r = ($urandom_range(0, 99) == 0);
         f = ($urandom_range(0, 7) == 0);
         applyStimulus(r, f, ($urandom_range(0, 2) == 0), $urandom, $urandom_range(0, 1) == 1);
         s = lastStall;
         advance();
         if (r) pc = '0;
         else if (!s) begin
            rnd = $urandom;
            pc = f ? {rnd[31:2], 2'b00} : pc + 32'd4;
         end
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, which is the number of WAIT cycles without imem_ack before the fetch is declared failed.
REQ-002 The module SHALL have parameter NOP_INST, default 32'h00000013, which is the value driven on inst while no valid instruction is held.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk SHALL be: input, 1 bit, sole clock, rising edge.
REQ-005 Port rst SHALL be: input, 1 bit, synchronous active-high reset.
REQ-006 Port pc SHALL be: input, 32 bits, current fetch address from the PC register.
REQ-007 Port flush SHALL be: input, 1 bit, one-cycle redirect pulse that kills the held or in-flight instruction.
REQ-008 Port imem_req SHALL be: output, 1 bit, instruction-memory request.
REQ-009 Port imem_addr SHALL be: output, 32 bits, request address.
REQ-010 Port imem_ack SHALL be: input, 1 bit, memory data valid, accepted only while imem_req=1.
REQ-011 Port imem_rdata SHALL be: input, 32 bits, memory read data, qualified by imem_ack.
REQ-012 Port inst SHALL be: output, 32 bits, fetched instruction.
REQ-013 Port inst_pc SHALL be: output, 32 bits, address of inst.
REQ-014 Port inst_valid SHALL be: output, 1 bit, inst is valid for decode.
REQ-015 Port inst_ready SHALL be: input, 1 bit, decode accepts inst.
REQ-016 Port stall SHALL be: output, 1 bit, hold the PC register when 1.
REQ-017 Port fetch_err SHALL be: output, 1 bit, sticky fetch-timeout flag.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, REQ, WAIT, FULL and ERR.
REQ-019 IDLE SHALL transition unconditionally to REQ on the next cycle, giving a one-cycle start gap after reset.
REQ-020 In REQ and WAIT, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_req SHALL be 0 in all other states.
REQ-021 In REQ or WAIT, imem_ack=1 SHALL capture imem_rdata into inst and the current pc into inst_pc, then move to FULL; if imem_ack=0, REQ SHALL move to WAIT.
REQ-022 In FULL, inst_valid SHALL be 1; inst_valid SHALL be 0 in every other state.
REQ-023 In FULL, inst_valid & inst_ready SHALL complete a handshake and move to REQ; otherwise inst and inst_pc SHALL hold.
REQ-024 stall SHALL equal ~((inst_valid & inst_ready) | flush), combinationally, so the PC advances exactly once per consumed instruction or redirect.
REQ-025 Minimum fetch latency SHALL be 1 cycle from REQ entry to inst_valid (ack in the REQ cycle); throughput SHALL be one instruction per 2 cycles at most.
REQ-026 A flush in FULL SHALL clear inst_valid and move to REQ; flush has priority over a simultaneous handshake, and no handshake is counted.
REQ-027 A flush in REQ or WAIT that coincides with imem_ack SHALL discard the data and move to REQ.
REQ-028 A flush in WAIT without ack SHALL set a drop flag; the next ack SHALL be discarded, the flag cleared, and the FSM moved to REQ; imem_req SHALL stay high throughout.
REQ-029 When inst_valid=0, inst SHALL read NOP_INST.
REQ-030 inst_pc SHALL hold its last captured value when inst_valid=0.
REQ-031 A flush in IDLE or ERR SHALL be ignored.

Reset
REQ-032 While rst=1, the module SHALL force state=IDLE, imem_req=0, inst=NOP_INST, inst_pc=0, inst_valid=0, stall=1, fetch_err=0, the drop flag to 0 and the timeout counter to 0.
REQ-033 rst asserted mid-fetch SHALL abandon the outstanding request; an ack arriving while in IDLE SHALL be ignored.

Configuration
REQ-034 With macro IFETCH_TIMEOUT_EN defined, a counter SHALL run in WAIT and clear on leaving WAIT.
REQ-035 With IFETCH_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES without ack SHALL move the FSM to ERR and set fetch_err=1 (sticky); ERR SHALL hold imem_req=0, inst_valid=0 and stall=1 until rst.
REQ-036 Without IFETCH_TIMEOUT_EN, no counter and no ERR state SHALL be built, WAIT SHALL persist indefinitely, and the fetch_err port SHALL remain, tied to 0.

Verification
REQ-037 The bench SHALL release rst with imem_ack tied to 1 and imem_rdata=32'h00500093 -> inst_valid rises 2 cycles after release, inst=32'h00500093 and inst_pc=0.
REQ-038 The bench SHALL hold inst_ready=0 for 5 cycles in FULL -> inst, inst_pc and inst_valid hold, stall=1, imem_req=0.
REQ-039 The bench SHALL delay ack by 3 cycles with pc=32'h10 -> imem_req high for 4 cycles, then inst_pc=32'h10.
REQ-040 The bench SHALL pulse flush in WAIT, then ack with 32'hDEADBEEF -> data discarded, inst_valid stays 0, a new request issued at the new pc.
REQ-041 The bench SHALL assert flush and inst_ready together in FULL -> inst_valid drops, stall=0 for that one cycle, FSM enters REQ.
REQ-042 With IFETCH_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, the bench SHALL never ack -> fetch_err=1 after 8 WAIT cycles and stays high until rst; without the macro, fetch_err=0 and imem_req stays 1.
